i2c_write_arbiter: RTL and testbench

I2C_WRITE_ARBITER -- requirements
Module: i2c_write_arbiter

---
 rtl/i2c_write_arbiter.sv | 133 +++++++++++++
 tb/tb_i2c_write_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_arbiter.sv
// Round-robin arbiter that serialises N register-write requesters onto one shared
// I2C write master, with NACK retry and a WAIT-phase timeout.
module i2c_write_arbiter #(
    parameter int N           = 4,
    parameter int MAX_RETRY   = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req_valid,
    input  logic [7*N-1:0]   req_addr,
    input  logic [8*N-1:0]   req_reg,
    input  logic [8*N-1:0]   req_data,
    output logic [N-1:0]     req_ready,
    output logic [N-1:0]     resp_valid,
    output logic [1:0]       resp_code,
    output logic             m_go,
    output logic [6:0]       m_addr,
    output logic [7:0]       m_reg,
    output logic [7:0]       m_data,
    input  logic             m_busy,
    input  logic             m_done,
    input  logic             m_nack
);
    localparam int IW = $clog2(N);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    // Compare one below the last count so RESP lands exactly TIMEOUT_CYC cycles after m_go.
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 2);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    localparam logic [1:0] CODE_OK   = 2'b00;
    localparam logic [1:0] CODE_NACK = 2'b01;
    localparam logic [1:0] CODE_TO   = 2'b10;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t         state;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  grant;
    logic [RW-1:0]  retry_cnt;
    logic [TW-1:0]  timeout_cnt;

    logic           win_any;
    logic [IW-1:0]  win_idx;
    logic [N-1:0]   win_oh;
    logic [N-1:0]   grant_oh;

    // First requesting index at or after rr_ptr, wrapping around.
    always_comb begin
        int j;
        logic [IW-1:0] j_idx;
        win_any = 1'b0;
        win_idx = '0;
        j       = 0;
        j_idx   = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= N) j = j - N;
            j_idx = IW'(j);
            if (!win_any && req_valid[j_idx]) begin
                win_any = 1'b1;
                win_idx = j_idx;
            end
        end
    end

    assign win_oh    = {{(N-1){1'b0}}, 1'b1} << win_idx;
    assign grant_oh  = {{(N-1){1'b0}}, 1'b1} << grant;
    assign req_ready = (state == IDLE && win_any) ? win_oh : '0;
    assign m_go      = (state == LAUNCH) && !m_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant       <= '0;
            retry_cnt   <= '0;
            timeout_cnt <= '0;
            resp_valid  <= '0;
            resp_code   <= CODE_OK;
            m_addr      <= '0;
            m_reg       <= '0;
            m_data      <= '0;
        end else begin
            resp_valid <= '0;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        m_addr    <= req_addr[7*int'(win_idx) +: 7];
                        m_reg     <= req_reg[8*int'(win_idx) +: 8];
                        m_data    <= req_data[8*int'(win_idx) +: 8];
                        grant     <= win_idx;
                        retry_cnt <= '0;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (!m_busy) begin
                        timeout_cnt <= '0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                    if (m_done) begin
                        if (!m_nack) begin
                            resp_code  <= CODE_OK;
                            resp_valid <= grant_oh;
                            state      <= RESP;
                        end else if (retry_cnt < RETRY_MAX) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= LAUNCH;
                        end else begin
                            resp_code  <= CODE_NACK;
                            resp_valid <= grant_oh;
                            state      <= RESP;
                        end
                    end else if (timeout_cnt == TO_LAST) begin
                        resp_code  <= CODE_TO;
                        resp_valid <= grant_oh;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr <= (int'(grant) == N - 1) ? '0 : grant + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Self-checking bench for i2c_write_arbiter: vector table plus hand sequences,
// responses checked through a scoreboard queue.
module tb_i2c_write_arbiter;
    localparam int N           = 4;
    localparam int MAX_RETRY   = 2;
    localparam int TIMEOUT_CYC = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [7*N-1:0]   req_addr;
    logic [8*N-1:0]   req_reg;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     resp_valid;
    logic [1:0]       resp_code;
    logic             m_go;
    logic [6:0]       m_addr;
    logic [7:0]       m_reg;
    logic [7:0]       m_data;
    logic             m_busy;
    logic             m_done;
    logic             m_nack;

    i2c_write_arbiter #(.N(N), .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_reg(req_reg), .req_data(req_data),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_code(resp_code),
        .m_go(m_go), .m_addr(m_addr), .m_reg(m_reg), .m_data(m_data),
        .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack)
    );

    always #5 clk = ~clk;

    typedef struct { logic [N-1:0] oh; logic [1:0] code; } exp_t;
    typedef struct {
        logic [N-1:0] rv; int g; logic [6:0] a; logic [7:0] r; logic [7:0] d;
        int nack_n; bit to; logic [1:0] code; int gos; bit hold;
    } vec_t;

    exp_t sb[$];
    int   errors = 0, checks = 0;
    int   cyc = 0, go_cnt = 0, resp_cnt = 0, resp_cyc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_go) go_cnt++;
        if (resp_valid != '0) begin
            resp_cyc = cyc;
            resp_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_resp", {28'd0, resp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_valid", {28'd0, resp_valid}, {28'd0, e.oh});
                chk("resp_code", {30'd0, resp_code}, {30'd0, e.code});
            end
        end
    end

    task automatic set_fields(input logic [6:0] a, input logic [7:0] r, input logic [7:0] d);
        for (int i = 0; i < N; i++) begin
            req_addr[7*i +: 7] = a ^ 7'(i);
            req_reg[8*i +: 8]  = r + 8'(16 * i);
            req_data[8*i +: 8] = d + 8'(i);
        end
    endtask

    task automatic chk_fields(input string tag, input int g, input logic [6:0] a,
                              input logic [7:0] r, input logic [7:0] d);
        chk({tag, "_m_addr"}, {25'd0, m_addr}, {25'd0, a ^ 7'(g)});
        chk({tag, "_m_reg"},  {24'd0, m_reg},  {24'd0, r + 8'(16 * g)});
        chk({tag, "_m_data"}, {24'd0, m_data}, {24'd0, d + 8'(g)});
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '0; m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0;
        set_fields(7'h00, 8'h00, 8'h00);
        @(negedge clk); @(negedge clk);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {28'd0, resp_valid}, 32'd0);
        chk("rst_resp_code", {30'd0, resp_code}, 32'd0);
        chk("rst_m_go", {31'd0, m_go}, 32'd0);
        chk("rst_fields", {9'd0, m_addr, m_reg, m_data}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // One full transaction; entered just after a negedge.
    task automatic run_txn(input vec_t v);
        int t, go0, go_cyc, done_cyc;
        go_cyc = 0; done_cyc = 0;
        set_fields(v.a, v.r, v.d);
        req_valid = v.rv;
        #1;
        t = 0;
        while (req_ready == '0 && t < 20) begin @(negedge clk); #1; t++; end
        chk("req_ready", {28'd0, req_ready}, 32'd1 << v.g);
        sb.push_back('{oh: N'(1) << v.g, code: v.code});
        go0 = go_cnt;
        @(negedge clk);
        if (!v.hold) req_valid = '0;
        for (int k = 0; k < v.gos; k++) begin
            t = 0;
            while (!m_go && t < 20) begin @(negedge clk); t++; end
            if (k == 0) chk("go_latency", t, 0);
            chk("m_go", {31'd0, m_go}, 32'd1);
            chk_fields("launch", v.g, v.a, v.r, v.d);
            go_cyc = cyc;
            if (v.to) break;
            @(negedge clk);
            m_done = 1'b1; m_nack = (k < v.nack_n); done_cyc = cyc;
            @(negedge clk);
            m_done = 1'b0; m_nack = 1'b0;
        end
        t = 0;
        while (sb.size() != 0 && t < TIMEOUT_CYC + 20) begin @(negedge clk); t++; end
        chk("resp_arrived", sb.size(), 0);
        if (v.to) chk("timeout_latency", resp_cyc - go_cyc, TIMEOUT_CYC);
        else      chk("resp_latency", resp_cyc - done_cyc, 1);
        chk("go_count", go_cnt - go0, v.gos);
    endtask

    vec_t tbl[7];
    vec_t con[5];

    initial begin
        int go0, r0;
        // rr_ptr walks 0 -> 1 -> 3 -> 1 -> 0 -> 2 -> 2 -> 3 across these rows
        tbl[0] = '{4'b0001, 0, 7'h50, 8'h10, 8'hA5, 0, 1'b0, 2'b00, 1, 1'b0};
        tbl[1] = '{4'b0101, 2, 7'h21, 8'h30, 8'h01, 0, 1'b0, 2'b00, 1, 1'b0};
        tbl[2] = '{4'b0011, 0, 7'h3C, 8'h44, 8'h5A, 2, 1'b0, 2'b00, 3, 1'b0};
        tbl[3] = '{4'b1000, 3, 7'h11, 8'h02, 8'hC3, 3, 1'b0, 2'b01, 3, 1'b0};
        tbl[4] = '{4'b0110, 1, 7'h68, 8'h7F, 8'h00, 0, 1'b1, 2'b10, 1, 1'b0};
        tbl[5] = '{4'b0010, 1, 7'h08, 8'h09, 8'h0A, 0, 1'b0, 2'b00, 1, 1'b0};
        tbl[6] = '{4'b1110, 2, 7'h77, 8'hEE, 8'h99, 0, 1'b0, 2'b00, 1, 1'b0};
        for (int i = 0; i < 5; i++)
            con[i] = '{4'b1111, i % N, 7'h40, 8'h20, 8'h80, 0, 1'b0, 2'b00, 1, (i < 4)};

        do_reset();
        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // Busy hold-off, with a requester that withdraws before being accepted.
        @(negedge clk);
        m_busy = 1'b1;
        set_fields(7'h2A, 8'h33, 8'h44);
        req_valid = 4'b0001;
        #1 chk("busy_ready", {28'd0, req_ready}, 32'd1);
        sb.push_back('{oh: 4'b0001, code: 2'b00});
        go0 = go_cnt;
        @(negedge clk);
        req_valid = '0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) req_valid = 4'b1000;
            if (i == 10) req_valid = '0;
            if (i == 7) chk("ready_outside_idle", {28'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        chk("busy_no_go", go_cnt - go0, 0);
        set_fields(7'h00, 8'h00, 8'h00);
        m_busy = 1'b0;
        #1 chk("busy_go", {31'd0, m_go}, 32'd1);
        chk_fields("busy", 0, 7'h2A, 8'h33, 8'h44);
        @(negedge clk);
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        @(negedge clk);
        chk("busy_resp", sb.size(), 0);
        r0 = resp_cnt;
        repeat (4) @(negedge clk);
        chk("withdrawn_no_grant", {28'd0, req_ready}, 32'd0);
        chk("withdrawn_no_resp", resp_cnt - r0, 0);

        do_reset();
        for (int i = 0; i < 5; i++) run_txn(con[i]);

        // Reset while waiting on the master, then a stale m_done.
        @(negedge clk);
        set_fields(7'h55, 8'h66, 8'h77);
        req_valid = 4'b0100;
        #1 chk("abort_ready", {28'd0, req_ready}, 32'd4);
        @(negedge clk);
        req_valid = '0;
        chk("abort_go", {31'd0, m_go}, 32'd1);
        @(negedge clk);
        r0 = resp_cnt;
        reset = 1'b1;
        #1;
        chk("abort_rst_resp", {28'd0, resp_valid}, 32'd0);
        chk("abort_rst_fields", {9'd0, m_addr, m_reg, m_data}, 32'd0);
        chk("abort_rst_code", {30'd0, resp_code}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_resp", resp_cnt - r0, 0);
        chk("abort_go_idle", {31'd0, m_go}, 32'd0);
        run_txn('{4'b1111, 0, 7'h12, 8'h34, 8'h56, 0, 1'b0, 2'b00, 1, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
